// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: merges up to four completed results per cycle, broadcasts two
// in age order on registered CDB ports, and queues leftovers in a circular FIFO.
module cdb_arbiter #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ld_v_i,
    input  logic [TAG_W-1:0]         ld_tag_i,
    input  logic [DATA_W-1:0]        ld_val_i,
    input  logic                     ld2_v_i,
    input  logic [TAG_W-1:0]         ld2_tag_i,
    input  logic [DATA_W-1:0]        ld2_val_i,
    input  logic                     alu_v_i,
    input  logic [TAG_W-1:0]         alu_tag_i,
    input  logic [DATA_W-1:0]        alu_val_i,
    input  logic                     alu2_v_i,
    input  logic [TAG_W-1:0]         alu2_tag_i,
    input  logic [DATA_W-1:0]        alu2_val_i,
    output logic                     cdb_v_o,
    output logic [TAG_W-1:0]         cdb_tag_o,
    output logic [DATA_W-1:0]        cdb_val_o,
    output logic                     cdb2_v_o,
    output logic [TAG_W-1:0]         cdb2_tag_o,
    output logic [DATA_W-1:0]        cdb2_val_o,
    output logic                     stall_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } res_t;

    res_t            mem_q [DEPTH];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, head1;
    logic [CntW-1:0] count_q, count_d, space;
    logic            ovf_q, ovf_d;
    logic            s0_v_q, s0_v_d, s1_v_q, s1_v_d;
    res_t            s0_q, s0_d, s1_q, s1_d;

    res_t            in_r [4];
    logic [3:0]      in_v;
    res_t            in_c [4];
    logic [2:0]      n_in, left, push;
    logic [1:0]      pop, avail, take, idx;
    logic [3:0]      wr_en;
    logic [PtrW-1:0] wr_ptr [4];
    res_t            wr_data [4];

    assign in_v    = {alu2_v_i, alu_v_i, ld2_v_i, ld_v_i};
    assign in_r[0] = '{tag: ld_tag_i,   val: ld_val_i};
    assign in_r[1] = '{tag: ld2_tag_i,  val: ld2_val_i};
    assign in_r[2] = '{tag: alu_tag_i,  val: alu_val_i};
    assign in_r[3] = '{tag: alu2_tag_i, val: alu2_val_i};

    // Compact valid inputs into fixed priority order ld, ld2, alu, alu2.
    always_comb begin
        n_in = '0;
        for (int i = 0; i < 4; i++) in_c[i] = '0;
        for (int i = 0; i < 4; i++) begin
            if (in_v[i]) begin
                in_c[n_in[1:0]] = in_r[i];
                n_in = n_in + 3'd1;
            end
        end
    end

    always_comb begin
        pop    = (count_q >= CntW'(2)) ? 2'd2 : count_q[1:0];
        avail  = 2'd2 - pop;
        take   = (n_in < {1'b0, avail}) ? n_in[1:0] : avail;
        left   = n_in - {1'b0, take};
        space  = CntW'(DEPTH) - count_q + CntW'(pop);
        // Leftovers beyond free space are dropped newest first.
        push   = (CntW'(left) <= space) ? left : space[2:0];
        ovf_d  = ovf_q | (push != left);
        head1  = head_q + PtrW'(1);

        s0_v_d = 1'b0;
        s0_d   = '0;
        s1_v_d = 1'b0;
        s1_d   = '0;
        if (pop != 2'd0) begin
            s0_v_d = 1'b1;
            s0_d   = mem_q[head_q];
        end else if (n_in != 3'd0) begin
            s0_v_d = 1'b1;
            s0_d   = in_c[0];
        end
        unique case (pop)
            2'd2: begin
                s1_v_d = 1'b1;
                s1_d   = mem_q[head1];
            end
            2'd1: begin
                if (n_in >= 3'd1) begin
                    s1_v_d = 1'b1;
                    s1_d   = in_c[0];
                end
            end
            default: begin
                if (n_in >= 3'd2) begin
                    s1_v_d = 1'b1;
                    s1_d   = in_c[1];
                end
            end
        endcase

        for (int k = 0; k < 4; k++) begin
            idx        = take + 2'(k);
            wr_en[k]   = 3'(k) < push;
            wr_ptr[k]  = tail_q + PtrW'(k);
            wr_data[k] = in_c[idx];
        end

        count_d = count_q - CntW'(pop) + CntW'(push);
        head_d  = head_q + PtrW'(pop);
        tail_d  = tail_q + PtrW'(push);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            s0_v_q  <= 1'b0;
            s1_v_q  <= 1'b0;
            s0_q    <= '0;
            s1_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            s0_v_q  <= s0_v_d;
            s1_v_q  <= s1_v_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
        end
    end

    // Storage needs no reset; count/pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_en[k]) mem_q[wr_ptr[k]] <= wr_data[k];
            end
        end
    end

    assign cdb_v_o    = s0_v_q;
    assign cdb_tag_o  = s0_q.tag;
    assign cdb_val_o  = s0_q.val;
    assign cdb2_v_o   = s1_v_q;
    assign cdb2_tag_o = s1_q.tag;
    assign cdb2_val_o = s1_q.val;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign stall_o    = count_q > CntW'(DEPTH - 4);

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter sitting directly downstream of the two ALUs and the two load-result paths (data-memory/store-buffer forwarding muxes) in the out-of-order core. Each cycle it collects up to four completed results (tag + value), selects at most two in age order, and broadcasts them on two registered CDB ports consumed by the ROB, arithmetic reservation station, load/store reservation station and jr wait register. Results not broadcast immediately are held in an internal FIFO, and a stall output throttles producers before the FIFO can overflow.

## Interface
- DEPTH, 8, leftover-result FIFO entries; power of two, ≥ 4
- TAG_W, 5, ROB tag width
- DATA_W, 32, result width

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ld_v / ld_tag / ld_val  in  1 / TAG_W / DATA_W  load result port 1
- ld2_v / ld2_tag / ld2_val  in  1 / TAG_W / DATA_W  load result port 2
- alu_v / alu_tag / alu_val  in  1 / TAG_W / DATA_W  ALU1 result
- alu2_v / alu2_tag / alu2_val  in  1 / TAG_W / DATA_W  ALU2 result
- cdb_v / cdb_tag / cdb_val  out  1 / TAG_W / DATA_W  broadcast slot 0 (registered)
- cdb2_v / cdb2_tag / cdb2_val  out  1 / TAG_W / DATA_W  broadcast slot 1 (registered)
- stall  out  1  producers must not assert any *_v this cycle
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: a result was dropped

## Operation
- Candidate list each cycle, in priority order: FIFO entries oldest→newest, then new inputs in fixed order ld, ld2, alu, alu2 (only those with valid high).
- First candidate → slot 0, second → slot 1; remaining candidates, in order, written to FIFO tail. FIFO entries consumed are popped from head.
- Slot 1 is never valid unless slot 0 is valid; two results always go out in age order (slot 0 older).
- stall = (count > DEPTH-4), combinational from registered count. Guarantees count+4-2 ≤ DEPTH-2 when producers obey it.
- Producer violation (input valid while stall high) is still accepted if space exists; any candidate that cannot fit after selection is dropped, newest first, and overflow sets, remaining set until rst.
- No tag comparison or deduplication; identical tags are broadcast as separate results.
- FIFO: circular buffer, head/tail pointers wrap modulo DEPTH; count distinguishes full from empty; push and pop in the same cycle are allowed.
- Reset: cdb_v, cdb2_v = 0; cdb_tag, cdb2_tag, cdb_val, cdb2_val = 0; count = 0; head = tail = 0; overflow = 0; stall = 0. Inputs present during the rst cycle are discarded.

## Timing
- Latency: input valid in cycle N with empty FIFO and ≤ 2 inputs → broadcast in cycle N+1.
- Each queued result adds one cycle per two older results ahead of it.
- Outputs change only on rising edge; cdb_v/cdb2_v high for exactly one cycle per result.
- count and stall reflect state after the previous edge; stall asserted in cycle N applies to inputs sampled in cycle N.
- Throughput: 2 results/cycle; sustained 4/cycle fills FIFO by 2/cycle until stall.
- Reset mid-operation clears queued results with no broadcast.

## Test plan
- Single alu_v, tag 3, val 0x0000_00AA, FIFO empty -> next cycle cdb_v=1, tag 3, val 0xAA; cdb2_v=0; count 0.
- All four valid in one cycle (ld tag 1, ld2 tag 2, alu tag 3, alu2 tag 4) -> cycle+1: cdb tags 1,2; count 2; cycle+2: cdb tags 3,4; count 0.
- Four valid every cycle, honouring stall, DEPTH 8 -> count 2, 4, then stall=1 at count 6; with inputs idle, drains 2/cycle in tag order with no loss; overflow stays 0.
- With 1 entry queued (tag 5), single new ld tag 6 -> slot 0 tag 5, slot 1 tag 6 on the same cycle.
- Force count 8 (full), drive all four valid ignoring stall -> 2 oldest broadcast, 2 pushed, 2 newest (alu, alu2) dropped; overflow=1 and held.
- Assert rst with count 4 and inputs valid -> next cycle all outputs 0, count 0, overflow 0, no broadcast of queued tags afterward.
